// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet parser.
package uart_pkt_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LEN     = 3'd1,
      PAYLOAD = 3'd2,
      CSUM    = 3'd3,
      DRAIN   = 3'd4
   } state_e;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_LEN     = 3'd1;
   localparam logic [2:0] ERR_CSUM    = 3'd2;
   localparam logic [2:0] ERR_FRAME   = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;
   localparam logic [2:0] ERR_OVERRUN = 3'd5;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload store: MAX_LEN x 8 register file, one synchronous write port and one
// combinational read port. Contents survive reset.
module uart_pkt_buf #(
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned AW      = 4
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [MAX_LEN];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_pkt_parser.sv
// Frame parser behind uart_rx: SOF, LEN, LEN payload bytes, XOR checksum.
// Payload is buffered and released on a valid/ready stream only once the checksum matches.
module uart_rx_pkt_parser
   import uart_pkt_pkg::*;
#(
   parameter int unsigned MAX_LEN      = 16,
   parameter logic [7:0]  SOF          = SOF_DEFAULT,
   parameter int unsigned TIMEOUT_CLKS = 43400
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       framing_error,
   output logic [7:0] m_data,
   output logic       m_valid,
   output logic       m_last,
   input  logic       m_ready,
   output logic       pkt_ok,
   output logic       pkt_err,
   output logic [2:0] err_code,
   output logic       busy
);

   localparam int unsigned PTR_W = $clog2(MAX_LEN + 1);
   localparam int unsigned AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CLKS);

   state_e           state_q, state_d;
   logic [PTR_W-1:0] len_q, len_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]       csum_q, csum_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             pkt_ok_q, pkt_ok_d;
   logic             pkt_err_q, pkt_err_d;
   logic [2:0]       err_code_q, err_code_d;
   logic             byte_acc;
   logic             buf_we;
   logic             at_last;
   logic [7:0]       buf_rdata;

   // A framing error in the same cycle as rx_valid poisons the byte.
   assign byte_acc = rx_valid && !framing_error;
   assign at_last  = (rd_ptr_q == len_q - 1'b1);

   uart_pkt_buf #(
      .MAX_LEN(MAX_LEN),
      .AW     (AW)
   ) u_buf (
      .clk_i  (clk),
      .we_i   (buf_we),
      .waddr_i(wr_ptr_q[AW-1:0]),
      .wdata_i(rx_data),
      .raddr_i(rd_ptr_q[AW-1:0]),
      .rdata_o(buf_rdata)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      csum_d     = csum_q;
      tmo_d      = tmo_q;
      pkt_ok_d   = 1'b0;
      pkt_err_d  = 1'b0;
      err_code_d = err_code_q;
      buf_we     = 1'b0;

      case (state_q)
         IDLE: begin
            if (byte_acc && rx_data == SOF) begin
               state_d = LEN;
               csum_d  = 8'h00;
               tmo_d   = '0;
            end
         end

         LEN, PAYLOAD, CSUM: begin
            if (framing_error) begin
               state_d    = IDLE;
               pkt_err_d  = 1'b1;
               err_code_d = ERR_FRAME;
            end else if (byte_acc) begin
               tmo_d = '0;
               case (state_q)
                  LEN: begin
                     if (rx_data == 8'h00 || rx_data > 8'(MAX_LEN)) begin
                        state_d    = IDLE;
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                     end else begin
                        state_d  = PAYLOAD;
                        len_d    = rx_data[PTR_W-1:0];
                        csum_d   = rx_data;
                        wr_ptr_d = '0;
                     end
                  end
                  PAYLOAD: begin
                     buf_we   = 1'b1;
                     csum_d   = csum_q ^ rx_data;
                     wr_ptr_d = wr_ptr_q + 1'b1;
                     if (wr_ptr_q == len_q - 1'b1) begin
                        state_d = CSUM;
                     end
                  end
                  default: begin
                     if (rx_data == csum_q) begin
                        state_d  = DRAIN;
                        pkt_ok_d = 1'b1;
                        rd_ptr_d = '0;
                     end else begin
                        state_d    = IDLE;
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_CSUM;
                     end
                  end
               endcase
            end else begin
               if (tmo_q == TMO_LAST) begin
                  state_d    = IDLE;
                  pkt_err_d  = 1'b1;
                  err_code_d = ERR_TIMEOUT;
               end
               tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
            end
         end

         DRAIN: begin
            // Incoming bytes cannot be parsed while draining; drop and flag them.
            if (byte_acc) begin
               pkt_err_d  = 1'b1;
               err_code_d = ERR_OVERRUN;
            end
            if (m_ready) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
               if (at_last) begin
                  state_d = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         csum_q     <= 8'h00;
         tmo_q      <= '0;
         pkt_ok_q   <= 1'b0;
         pkt_err_q  <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         csum_q     <= csum_d;
         tmo_q      <= tmo_d;
         pkt_ok_q   <= pkt_ok_d;
         pkt_err_q  <= pkt_err_d;
         err_code_q <= err_code_d;
      end
   end

   assign m_valid  = (state_q == DRAIN);
   assign m_last   = m_valid && at_last;
   assign m_data   = m_valid ? buf_rdata : 8'h00;
   assign busy     = (state_q != IDLE);
   assign pkt_ok   = pkt_ok_q;
   assign pkt_err  = pkt_err_q;
   assign err_code = err_code_q;

endmodule
